// File: rtl/led_sequencer.sv
// led_sequencer: steps an LED animation on every toggle of the 1 Hz divider level.
// Modes: BLINK, SHIFT, PINGPONG, COUNT; mode/pause come from async board switches.
// Optional macro SEQ_REVERSE_EN adds dir_sw (reverse SHIFT rotation / COUNT direction).
module led_sequencer #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLOCK_50,
  input  logic             rst_in,
  input  logic             h_in,
  input  logic [1:0]       mode_sw,
  input  logic             pause_sw,
`ifdef SEQ_REVERSE_EN
  input  logic             dir_sw,
`endif
  output logic [WIDTH-1:0] LEDG,
  output logic             step_out
);

  typedef enum logic [1:0] {
    MODE_BLINK    = 2'd0,
    MODE_SHIFT    = 2'd1,
    MODE_PINGPONG = 2'd2,
    MODE_COUNT    = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [SYNC_STAGES-1:0][1:0] r_mode_sync;
  logic [SYNC_STAGES-1:0]      r_pause_sync;
  logic                        r_h_d;
  mode_t                       r_mode_q;
  dir_t                        r_pp_dir;
  logic [WIDTH-1:0]            r_ledg;
  logic                        r_step;

  mode_t            w_mode_s;
  logic             w_pause_s;
  logic             w_rev;
  logic             w_step;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_init;
  dir_t             w_pp_dir_next;

  // Shift the async mode and pause switches through their synchronizer chains.
  always_ff @(posedge CLOCK_50) begin
    if (rst_in) begin
      r_mode_sync  <= '0;
      r_pause_sync <= '0;
    end else begin
      r_mode_sync  <= {r_mode_sync[SYNC_STAGES-2:0], mode_sw};
      r_pause_sync <= {r_pause_sync[SYNC_STAGES-2:0], pause_sw};
    end
  end

`ifdef SEQ_REVERSE_EN
  logic [SYNC_STAGES-1:0] r_dir_sync;

  // Synchronize the direction switch.
  always_ff @(posedge CLOCK_50) begin
    if (rst_in) begin
      r_dir_sync <= '0;
    end else begin
      r_dir_sync <= {r_dir_sync[SYNC_STAGES-2:0], dir_sw};
    end
  end

  assign w_rev = r_dir_sync[SYNC_STAGES-1];
`else
  assign w_rev = 1'b0;
`endif

  assign w_mode_s  = mode_t'(r_mode_sync[SYNC_STAGES-1]);
  assign w_pause_s = r_pause_sync[SYNC_STAGES-1];
  assign w_step    = (h_in != r_h_d) & ~w_pause_s;

  // Next pattern for one step in the current mode, plus the reload value for a new mode.
  always_comb begin
    w_next        = r_ledg;
    w_pp_dir_next = r_pp_dir;
    w_init        = (w_mode_s == MODE_SHIFT || w_mode_s == MODE_PINGPONG) ? ONE : '0;
    unique case (r_mode_q)
      MODE_BLINK: w_next = ~r_ledg;
      MODE_SHIFT: w_next = w_rev ? {r_ledg[0], r_ledg[WIDTH-1:1]}
                                 : {r_ledg[WIDTH-2:0], r_ledg[WIDTH-1]};
      MODE_PINGPONG: begin
        // Direction flips as the lit LED lands on an end, so the end is shown once.
        if (r_pp_dir == DIR_LEFT) begin
          w_next = r_ledg << 1;
          if (w_next[WIDTH-1]) w_pp_dir_next = DIR_RIGHT;
        end else begin
          w_next = r_ledg >> 1;
          if (w_next[0]) w_pp_dir_next = DIR_LEFT;
        end
      end
      MODE_COUNT: w_next = w_rev ? (r_ledg - ONE) : (r_ledg + ONE);
    endcase
  end

  // Sequencer state: mode reload takes priority over a same-cycle step.
  always_ff @(posedge CLOCK_50) begin
    if (rst_in) begin
      r_h_d    <= h_in;
      r_mode_q <= MODE_BLINK;
      r_pp_dir <= DIR_LEFT;
      r_ledg   <= '0;
      r_step   <= 1'b0;
    end else begin
      r_h_d  <= h_in;
      r_step <= 1'b0;
      if (w_mode_s != r_mode_q) begin
        r_mode_q <= w_mode_s;
        r_ledg   <= w_init;
        r_pp_dir <= DIR_LEFT;
      end else if (w_step) begin
        r_ledg   <= w_next;
        r_pp_dir <= w_pp_dir_next;
        r_step   <= 1'b1;
      end
    end
  end

  assign LEDG     = r_ledg;
  assign step_out = r_step;

endmodule

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
- Downstream stage of the 1 s clock divider on the board: consumes the divider's toggling 1 Hz output level and drives the 8 green LEDs with a selectable animation.
- Each toggle of the input (either edge) is one step.
- Mode and pause come from board switches and are synchronized internally.

Parameters:
- WIDTH, 8, number of LEDs / pattern width (min 2).
- SYNC_STAGES, 2, flip-flop stages on asynchronous switch inputs (min 2).

Ports:
- CLOCK_50  input  1  system clock, 50 MHz.
- rst_in  input  1  synchronous reset, active-high.
- h_in  input  1  toggling level from the 1 s divider, same clock domain.
- mode_sw  input  2  async mode select: 0 BLINK, 1 SHIFT, 2 PINGPONG, 3 COUNT.
- pause_sw  input  1  async; high freezes the pattern.
- dir_sw  input  1  async; only present when SEQ_REVERSE_EN is defined.
- LEDG  output  WIDTH  LED pattern, registered.
- step_out  output  1  one-cycle pulse, high in the cycle LEDG advanced.

Behaviour:
- Reset (rst_in high at a rising edge):
  - LEDG=0, step_out=0, direction flag = left.
  - Switch synchronizers and the registered mode (mode_q) cleared to 0 (BLINK).
  - h_d loads the current h_in, so no spurious step after reset release.
- Step detect: step = (h_in != h_d) & ~pause_s. h_d <= h_in every cycle.
- LEDG latency: LEDG and step_out update at the same edge that samples the changed h_in, so new LEDG is visible 1 cycle after h_in toggles.
- Switch path: mode_sw, pause_sw and dir_sw each pass through a SYNC_STAGES flop chain, giving mode_s, pause_s and dir_s.
- Mode change: when mode_s != mode_q:
  - mode_q <= mode_s.
  - LEDG reloads the new mode's initial value; direction = left.
  - step_out=0.
  - Mode change wins over a simultaneous step; that step is dropped.
  - Latency from mode_sw change to reload: SYNC_STAGES+1 cycles.
- Pause: steps are ignored while pause_s=1 and are not queued. LEDG holds. Mode changes are still honoured while paused.
- Per-step update, by mode:
  - BLINK: init 0; each step LEDG <= ~LEDG (0x00, 0xFF, 0x00, ...).
  - SHIFT: init 1; each step rotate left by 1; bit WIDTH-1 wraps to bit 0 (0x80 -> 0x01).
  - PINGPONG: init 1, direction left.
    - Shift in the current direction. On reaching bit WIDTH-1 going left, direction flips to right (takes effect on the next step), and the reverse for bit 0.
    - Sequence for 8: 01,02,04,...,80,40,...,02,01,02,... with period 2*(WIDTH-1)=14 steps.
    - Exactly one LED lit at all times; an end LED is never shown twice in a row.
  - COUNT: init 0; LEDG <= LEDG+1 modulo 2^WIDTH (0xFF -> 0x00).
- step_out: 1 only in a cycle where a step was applied; 0 on reload, pause and reset.
- Reset mid-operation: overrides everything in that cycle.

Optional Feature:
- Macro: SEQ_REVERSE_EN.
- Defined:
  - Adds the dir_sw port and its synchronizer.
  - With dir_s=1, SHIFT rotates right (0x01 -> 0x80) and COUNT decrements (0x00 -> 0xFF). BLINK and PINGPONG are unaffected.
  - A dir_s change does not reload the pattern; it applies from the next step.
- Undefined: no dir_sw port; SHIFT always rotates left and COUNT always increments.

Test Plan:
- Reset with h_in=1, then hold h_in steady 20 cycles -> LEDG=0x00, step_out never asserts.
- mode_sw=1 from reset, toggle h_in 9 times, 10 cycles apart:
  - LEDG reloads to 0x01 at cycle SYNC_STAGES+1.
  - After the toggles: 02,04,08,10,20,40,80,01,02.
  - step_out pulses 9 times, 1 cycle each.
- mode_sw=2, 16 toggles -> 02,04,08,10,20,40,80,40,20,10,08,04,02,01,02,04.
- mode_sw=3:
  - Preload via 255 toggles -> 0xFF; next toggle -> 0x00.
  - pause_sw=1 then 5 toggles -> LEDG stays 0x00, no step_out.
  - pause_sw=0, 1 toggle -> 0x01.
- Simultaneous events: mode change from 1 to 0 lands in the same cycle as an h_in toggle -> LEDG=0x00, step_out=0. The next toggle gives 0xFF.
- SEQ_REVERSE_EN, mode 1, dir_sw=1 -> LEDG 0x01 then 0x80, 0x40. Mode 3 from 0x00 -> 0xFF.
